// File: rtl/chip_74161_emu.sv
// Cycle-accurate 74161 4-bit synchronous counter emulator on the chip side of the pin bus.
// Pin inputs are synchronised, the pin clock is edge-detected in the Clk domain, and fault modes corrupt outputs.
module chip_74161_emu #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Fault,
    input  logic       Pin1,
    input  logic       Pin2,
    input  logic       Pin3,
    input  logic       Pin4,
    input  logic       Pin5,
    input  logic       Pin6,
    input  logic       Pin7,
    input  logic       Pin9,
    input  logic       Pin10,
    output logic       Pin11,
    output logic       Pin12,
    output logic       Pin13,
    output logic       Pin14,
    output logic       Pin15,
    output logic [7:0] EdgeCount
);

    localparam int NPIN = 9;

    localparam logic [1:0] FAULT_QA_LOW = 2'd1;
    localparam logic [1:0] FAULT_STEP2  = 2'd2;
    localparam logic [1:0] FAULT_RCO    = 2'd3;

    logic [NPIN-1:0]             pins_raw;
    logic [SYNC_STAGES*NPIN-1:0] chain_q;
    logic [SYNC_STAGES-1:0]      fill_q;
    logic [NPIN-1:0]             s_pins;

    logic       s_clr_n, s_clk, s_enp, s_load_n, s_ent;
    logic [3:0] s_data;

    logic       s_clk_d_q;
    logic       armed_q, armed_d;
    logic [3:0] q_q, q_d;
    logic [7:0] edge_q, edge_d;
    logic       enable_q;
    logic [1:0] fault_q;

    logic       rise;
    logic [3:0] step;
    logic       rco_raw;

    assign pins_raw = {Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};
    assign s_pins   = chain_q[SYNC_STAGES*NPIN-1 -: NPIN];

    assign s_clr_n  = s_pins[0];
    assign s_clk    = s_pins[1];
    assign s_data   = s_pins[5:2];
    assign s_enp    = s_pins[6];
    assign s_load_n = s_pins[7];
    assign s_ent    = s_pins[8];

    // The fill marker tracks when the last sync stage holds a real sample rather than its
    // reset zero, so a pin clock held high through reset release cannot fake a 0->1 edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            chain_q <= '0;
            fill_q  <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES*NPIN-1-NPIN:0], pins_raw};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rise = armed_q & s_clk & ~s_clk_d_q;
    assign step = (fault_q == FAULT_STEP2) ? 4'd2 : 4'd1;

    always_comb begin
        armed_d = armed_q | (fill_q[SYNC_STAGES-1] & ~s_clk);
        edge_d  = edge_q + {7'd0, rise};
        q_d     = q_q;
        if (!s_clr_n) begin
            q_d = 4'd0;
        end else if (rise && !s_load_n) begin
            q_d = s_data;
        end else if (rise && s_enp && s_ent) begin
            q_d = q_q + step;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s_clk_d_q <= 1'b0;
            armed_q   <= 1'b0;
            q_q       <= 4'd0;
            edge_q    <= 8'd0;
            enable_q  <= 1'b0;
            fault_q   <= 2'd0;
        end else begin
            s_clk_d_q <= s_clk;
            armed_q   <= armed_d;
            q_q       <= q_d;
            edge_q    <= edge_d;
            enable_q  <= Enable;
            fault_q   <= Fault;
        end
    end

    assign rco_raw = s_ent & (q_q == 4'hF);

    assign Pin11 = enable_q & q_q[3];
    assign Pin12 = enable_q & q_q[2];
    assign Pin13 = enable_q & q_q[1];
    assign Pin14 = enable_q & q_q[0] & (fault_q != FAULT_QA_LOW);
    assign Pin15 = enable_q & (rco_raw ^ (fault_q == FAULT_RCO));

    assign EdgeCount = edge_q;

endmodule

// File: tb/tb_chip_74161_emu.sv
// Directed bench for chip_74161_emu: a vector table for steady-state behaviour plus
// hand-written sequences for reset, latency and mid-count reset.
module tb_chip_74161_emu;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Enable;
    logic [1:0] Fault;
    logic       Pin1, Pin2, Pin3, Pin4, Pin5, Pin6, Pin7, Pin9, Pin10;
    logic       Pin11, Pin12, Pin13, Pin14, Pin15;
    logic [7:0] EdgeCount;

    int n_checks = 0;
    int n_fail   = 0;

    chip_74161_emu #(.SYNC_STAGES(2)) dut (
        .Clk(Clk), .Reset(Reset), .Enable(Enable), .Fault(Fault),
        .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
        .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
        .Pin11(Pin11), .Pin12(Pin12), .Pin13(Pin13), .Pin14(Pin14), .Pin15(Pin15),
        .EdgeCount(EdgeCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       clr_n;
        logic       load_n;
        logic       enp;
        logic       ent;
        logic [3:0] data;
        logic [1:0] fault;
        logic       enable;
        logic       pulse;
        logic [4:0] exp_pins;   // {QD, QC, QB, QA, RCO} as seen on Pin11..Pin15
        logic [7:0] exp_edges;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string n, logic clr_n, logic load_n, logic enp, logic ent,
                                logic [3:0] d, logic [1:0] f, logic en, logic p,
                                logic [4:0] pins, logic [7:0] e);
        vec_t v;
        v.name = n; v.clr_n = clr_n; v.load_n = load_n; v.enp = enp; v.ent = ent;
        v.data = d; v.fault = f; v.enable = en; v.pulse = p;
        v.exp_pins = pins; v.exp_edges = e;
        vq.push_back(v);
    endfunction

    function automatic logic [7:0] pins_now();
        return {3'b000, Pin11, Pin12, Pin13, Pin14, Pin15};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end else begin
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pin_clock();
        Pin2 = 1'b1;
        tick(6);
        Pin2 = 1'b0;
        tick(6);
    endtask

    initial begin
        //   name        clr ld enp ent data   flt en pls pins       edges
        add("cnt1",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b00010, 8'd1);
        add("cnt2",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b00100, 8'd2);
        add("cnt3",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b00110, 8'd3);
        add("cnt4",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b01000, 8'd4);
        add("cnt5",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b01010, 8'd5);
        add("cnt6",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b01100, 8'd6);
        add("cnt7",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b01110, 8'd7);
        add("cnt8",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b10000, 8'd8);
        add("cnt9",      1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b10010, 8'd9);
        add("cnt10",     1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b10100, 8'd10);
        add("cnt11",     1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b10110, 8'd11);
        add("cnt12",     1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b11000, 8'd12);
        add("cnt13",     1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b11010, 8'd13);
        add("cnt14",     1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b11100, 8'd14);
        add("cnt15_rco", 1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b11111, 8'd15);
        add("cnt_wrap",  1, 1, 1, 1, 4'h0, 2'd0, 1, 1, 5'b00000, 8'd16);
        add("load10",    1, 0, 1, 1, 4'hA, 2'd0, 1, 1, 5'b10100, 8'd17);
        add("clr_noclk", 0, 1, 1, 1, 4'hA, 2'd0, 1, 0, 5'b00000, 8'd17);
        add("clr_beats", 0, 0, 1, 1, 4'hF, 2'd0, 1, 1, 5'b00000, 8'd18);
        add("load15",    1, 0, 1, 1, 4'hF, 2'd0, 1, 1, 5'b11111, 8'd19);
        add("ent0_hold", 1, 1, 1, 0, 4'h0, 2'd0, 1, 1, 5'b11110, 8'd20);
        add("enp0_hold", 1, 1, 0, 1, 4'h0, 2'd0, 1, 1, 5'b11111, 8'd21);
        add("f2_clr",    0, 1, 1, 1, 4'h0, 2'd2, 1, 0, 5'b00000, 8'd21);
        add("f2_2",      1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b00100, 8'd22);
        add("f2_4",      1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b01000, 8'd23);
        add("f2_6",      1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b01100, 8'd24);
        add("f2_8",      1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b10000, 8'd25);
        add("f2_10",     1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b10100, 8'd26);
        add("f2_12",     1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b11000, 8'd27);
        add("f2_14",     1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b11100, 8'd28);
        add("f2_wrap0",  1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b00000, 8'd29);
        add("f0_load15", 1, 0, 1, 1, 4'hF, 2'd0, 1, 1, 5'b11111, 8'd30);
        add("f2_wrap1",  1, 1, 1, 1, 4'h0, 2'd2, 1, 1, 5'b00010, 8'd31);
        add("f1_qa0",    1, 1, 1, 1, 4'h0, 2'd1, 1, 0, 5'b00000, 8'd31);
        add("f1_cnt2",   1, 1, 1, 1, 4'h0, 2'd1, 1, 1, 5'b00100, 8'd32);
        add("f1_cnt3",   1, 1, 1, 1, 4'h0, 2'd1, 1, 1, 5'b00100, 8'd33);
        add("f0_q3",     1, 1, 1, 1, 4'h0, 2'd0, 1, 0, 5'b00110, 8'd33);
        add("f3_q3",     1, 1, 1, 1, 4'h0, 2'd3, 1, 0, 5'b00111, 8'd33);
        add("f3_ent0",   1, 1, 1, 0, 4'h0, 2'd3, 1, 0, 5'b00111, 8'd33);
        add("f3_q15",    1, 0, 1, 1, 4'hF, 2'd3, 1, 1, 5'b11110, 8'd34);
        add("f3_q15e0",  1, 1, 1, 0, 4'hF, 2'd3, 1, 0, 5'b11111, 8'd34);
        add("load5",     1, 0, 1, 1, 4'h5, 2'd0, 1, 1, 5'b01010, 8'd35);
        add("dis_6",     1, 1, 1, 1, 4'h0, 2'd0, 0, 1, 5'b00000, 8'd36);
        add("dis_7",     1, 1, 1, 1, 4'h0, 2'd0, 0, 1, 5'b00000, 8'd37);
        add("dis_8",     1, 1, 1, 1, 4'h0, 2'd0, 0, 1, 5'b00000, 8'd38);
        add("en_q8",     1, 1, 1, 1, 4'h0, 2'd0, 1, 0, 5'b10000, 8'd38);

        Reset = 1'b0; Enable = 1'b1; Fault = 2'd0;
        Pin1 = 1'b1; Pin2 = 1'b1; Pin3 = 1'b0; Pin4 = 1'b0; Pin5 = 1'b0; Pin6 = 1'b0;
        Pin7 = 1'b1; Pin9 = 1'b1; Pin10 = 1'b1;

        tick(3);
        check("reset_pins", pins_now(), 8'h00);
        check("reset_edges", EdgeCount, 8'd0);

        // Pin clock held high across reset release must not register as an edge.
        Reset = 1'b1;
        tick(10);
        check("noedge_pins", pins_now(), 8'h00);
        check("noedge_edges", EdgeCount, 8'd0);
        Pin2 = 1'b0;
        tick(6);

        foreach (vq[i]) begin
            Pin1 = vq[i].clr_n; Pin9 = vq[i].load_n; Pin7 = vq[i].enp; Pin10 = vq[i].ent;
            {Pin6, Pin5, Pin4, Pin3} = vq[i].data;
            Fault = vq[i].fault; Enable = vq[i].enable;
            tick(6);
            if (vq[i].pulse) pin_clock();
            else tick(6);
            check({vq[i].name, "_pins"}, pins_now(), {3'b000, vq[i].exp_pins});
            check({vq[i].name, "_edges"}, EdgeCount, vq[i].exp_edges);
        end

        // Pin-clock latency: Q=8 -> 9 lands on the third Clk edge after Pin2 rises.
        Pin2 = 1'b1;
        tick(1);
        check("lat_e1", pins_now(), 8'b000_10000);
        tick(1);
        check("lat_e2", pins_now(), 8'b000_10000);
        tick(1);
        check("lat_e3", pins_now(), 8'b000_10010);
        check("lat_edges", EdgeCount, 8'd39);
        Pin2 = 1'b0;
        tick(6);

        // Clear without a pin clock, same three-edge latency.
        Pin1 = 1'b0;
        tick(1);
        check("clr_e1", pins_now(), 8'b000_10010);
        tick(1);
        check("clr_e2", pins_now(), 8'b000_10010);
        tick(1);
        check("clr_e3", pins_now(), 8'b000_00000);
        Pin1 = 1'b1;
        tick(6);

        pin_clock();
        check("mid_q1", pins_now(), 8'b000_00010);
        check("mid_edges", EdgeCount, 8'd40);

        // Asynchronous reset mid-count clears outputs between clock edges.
        #2;
        Reset = 1'b0;
        #1;
        check("async_rst_pins", pins_now(), 8'h00);
        check("async_rst_edges", EdgeCount, 8'd0);
        tick(2);
        Reset = 1'b1;
        tick(10);
        check("post_rst_pins", pins_now(), 8'h00);
        check("post_rst_edges", EdgeCount, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
